// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: one radix-2 step per clock,
// fixed 33-edge latency from accept to the done pulse, with {hi,lo} presented on prod.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_a_raw;
  logic [CNT_W-1:0] r_count;

  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_fix;

  always_comb begin
    w_signed = ~op[0];
    w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;
    // multiply: {hi,lo} is the accumulator with the multiplier shifting out of lo
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // divide: {hi,lo} is {partial remainder, dividend/quotient}
    w_trial  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_trial - {1'b0, r_b};
    w_ge     = (w_trial >= {1'b0, r_b});
  end

  always_comb begin
    w_fix = '0;
    if (r_div0) begin
      w_fix = {r_a_raw, {WIDTH{1'b1}}};
    end else if (r_div) begin
      w_fix[2*WIDTH-1:WIDTH] = r_neg_r ? -r_hi : r_hi;
      w_fix[WIDTH-1:0]       = r_neg_q ? -r_lo : r_lo;
    end else begin
      w_fix = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_a_raw <= '0;
      r_count <= '0;
    end else begin
      done <= 1'b0;
      if (flush && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !flush) begin
              r_div   <= op[1];
              r_neg_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r <= w_signed & a[WIDTH-1];
              r_div0  <= op[1] & ~|b;
              r_a_raw <= a;
              r_hi    <= '0;
              r_lo    <= op[1] ? w_abs_a : w_abs_b;
              r_b     <= op[1] ? w_abs_b : w_abs_a;
              r_count <= '0;
              busy    <= 1'b1;
              r_state <= S_CALC;
            end
          end
          S_CALC: begin
            if (r_div) begin
              r_hi <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
            r_count <= r_count + 1'b1;
            if (r_count == CNT_W'(WIDTH - 1))
              r_state <= S_FIX;
          end
          S_FIX: begin
            prod    <= w_fix;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage of the multistage MIPS pipeline. Executes MULT, MULTU, DIV and DIVU. Produces the 64-bit {hi,lo} result that travels through EX/MEM and MEM/WB as the "prod" bus into the register file's $hi/$lo write port. Asserts busy so the hazard unit can stall IF/ID/EX while an operation is in flight.

Parameters:
WIDTH, 32, operand width; prod is 2*WIDTH. Only 32 is verified.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled only in IDLE
op     input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
a      input  32  rs operand (multiplicand / dividend); latched at accept
b      input  32  rt operand (multiplier / divisor); latched at accept
flush  input  1  synchronous abort of the in-flight operation
busy   output 1  1 while an accepted operation has not completed
done   output 1  one-cycle pulse; prod valid and updated this cycle
prod   output 64  [63:32] hi (upper product / remainder), [31:0] lo (lower product / quotient)

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, prod=0, all internal registers 0. Reset mid-operation abandons it; no done pulse follows.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: start=1 and flush=0 at edge E0 -> latch op, |a|, |b| (magnitudes for signed ops, raw for unsigned), result sign flags, iteration count=0. Enter CALC, busy=1 after E0.
- CALC: one radix-2 step per edge, E1..E32.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder / quotient.
  - count==31 at the step edge -> FIX.
- FIX (edge E33):
  - Apply sign correction, load prod, done=1, busy=0, state=IDLE.
  - done deasserts at E34.
- Fixed latency: done is high in the cycle after E33, i.e. 33 edges after the accepting edge, for every op including divide-by-zero.
- start while busy=1 is ignored, not queued. start sampled at E34, the cycle done is high, is accepted normally.
- Inputs a, b and op may change freely after acceptance.
- Signed multiply: 64-bit product negated when a[31]^b[31].
- Signed divide:
  - Quotient truncates toward zero; negated when a[31]^b[31].
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b==0, DIV or DIVU): lo=0xFFFFFFFF, hi=a as originally presented (signed value unchanged).
- flush=1 at any edge while not IDLE:
  - state=IDLE, busy=0, no done, prod holds its previous value.
  - flush in IDLE cancels a same-edge start (flush wins).
  - flush on E33 suppresses the FIX update.
- prod changes only on a FIX edge or on reset; it holds between operations.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at E0 -> busy high E0+1..E32, done high only in cycle after E33, prod=0xFFFFFFFE_00000001.
- MULT a=0xFFFFFFFD(-3) b=7 -> prod=0xFFFFFFFF_FFFFFFEB. MULT a=0x80000000 b=0x80000000 -> prod=0x40000000_00000000.
- DIV a=0xFFFFFFF9(-7) b=2 -> prod=0xFFFFFFFF_FFFFFFFD. DIVU a=100 b=7 -> prod=0x00000002_0000000E.
- DIV a=0x80000000 b=0xFFFFFFFF -> prod=0x00000000_80000000. DIVU a=5 b=0 -> prod=0x00000005_FFFFFFFF, same 33-edge latency.
- Interrupts: start pulsed at E5 of a running op is ignored, only one done. flush at E10 -> busy=0 at E10+, no done, prod keeps prior result. Async reset asserted mid-CALC -> busy/done/prod=0 immediately.
- Back-to-back: second start asserted in the done cycle is accepted. Second done follows exactly 33 edges later with the correct new result; a/b changed after accept do not affect it.
